// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU execute stage.
//   alu_op_e  - control-unit ALU opcode (load/store, branch, R/I-type, jump)
//   alu_sel_e - 5-bit internal operation select
//   state_e   - execute-stage handshake state
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_OP_MEM    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_REG    = 2'b10,
    ALU_OP_JUMP   = 2'b11
  } alu_op_e;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_XOR    = 5'h02,
    ALU_OR     = 5'h03,
    ALU_AND    = 5'h04,
    ALU_SLL    = 5'h05,
    ALU_SRL    = 5'h06,
    ALU_SRA    = 5'h07,
    ALU_SLT    = 5'h08,
    ALU_SLTU   = 5'h09,
    ALU_BEQ    = 5'h0A,
    ALU_BNE    = 5'h0B,
    ALU_BLT    = 5'h0C,
    ALU_BGE    = 5'h0D,
    ALU_BLTU   = 5'h0E,
    ALU_BGEU   = 5'h0F,
    ALU_MUL    = 5'h10,
    ALU_MULH   = 5'h11,
    ALU_MULHSU = 5'h12,
    ALU_MULHU  = 5'h13,
    ALU_DIV    = 5'h14,
    ALU_DIVU   = 5'h15,
    ALU_REM    = 5'h16,
    ALU_REMU   = 5'h17
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // M-extension selects occupy 0x10..0x17
  function automatic logic is_mext_sel(alu_sel_e s);
    return s[4];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 iterative multiply/divide for the M extension.
// Only instantiated when ALU_MEXT_EN is defined.
//   clk, rst_n   clock, async active-low reset
//   kill         abort; clears the iteration counter
//   start        load operands (func3 selects MUL..REMU)
//   step         one iteration per cycle while the parent is BUSY
//   func3        M-extension func3, latched on start
//   opa, opb     operands
//   last         counter is 0: the current step is the final one
//   result       sign-corrected result of the final step (valid with last)
module alu_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, mag_q;
  logic            is_div_q, sel_hi_q, neg_main_q, neg_rem_q;

  // operand magnitudes and sign bookkeeping at start
  logic            a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    a_sgn = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    b_sgn = func3[2] ? ~func3[0] : ~func3[1];
    neg_a = a_sgn & opa[XLEN-1];
    neg_b = b_sgn & opb[XLEN-1];
    mag_a = neg_a ? ('0 - opa) : opa;
    mag_b = neg_b ? ('0 - opb) : opb;
  end

  // one iteration: shift-add (multiply) or restoring shift-subtract (divide)
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] sub;
  logic            ge;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    add_sum = '0;
    shifted = '0;
    sub     = '0;
    ge      = 1'b0;
    if (is_div_q) begin
      shifted = {hi_q, lo_q[XLEN-1]};
      ge      = shifted >= {1'b0, mag_q};
      // true difference is below 2^XLEN whenever ge holds
      sub     = shifted[XLEN-1:0] - mag_q;
      hi_n    = ge ? sub : shifted[XLEN-1:0];
      lo_n    = {lo_q[XLEN-2:0], ge};
    end else begin
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
      hi_n    = add_sum[XLEN:1];
      lo_n    = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // sign correction applied to the outcome of the final step
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    prod   = {hi_n, lo_n};
    prod_c = neg_main_q ? ('0 - prod) : prod;
    quo    = neg_main_q ? ('0 - lo_n) : lo_n;
    rem    = neg_rem_q  ? ('0 - hi_n) : hi_n;
    if (is_div_q) result = sel_hi_q ? rem : quo;
    else          result = sel_hi_q ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0];
  end

  assign last = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mag_q      <= '0;
      is_div_q   <= 1'b0;
      sel_hi_q   <= 1'b0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (kill) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q      <= CW'(XLEN - 1);
      hi_q       <= '0;
      lo_q       <= func3[2] ? mag_a : mag_b;
      mag_q      <= func3[2] ? mag_b : mag_a;
      is_div_q   <= func3[2];
      sel_hi_q   <= func3[2] ? func3[1] : (func3[1:0] != 2'b00);
      neg_main_q <= neg_a ^ neg_b;
      neg_rem_q  <= neg_a;
    end else if (step) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execute stage with registered result and
// branch decision. Optional iterative M extension under macro ALU_MEXT_EN;
// without it, any mext_bit=1 request completes as illegal in one cycle.
//   clk, rst_n          clock, async active-low reset
//   kill                synchronous abort of the in-flight operation
//   in_valid/in_ready   operation handshake
//   alu_op, func3       control-unit opcode and instruction func3
//   sign_bit, mext_bit  instruction bits 30 and 25
//   opa, opb            operands
//   out_valid/out_ready result handshake
//   result              operation result (0 for branches and illegal ops)
//   branch_taken        branch condition (alu_op 01 only)
//   illegal             undefined encoding
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      func3,
  input  logic            sign_bit,
  input  logic            mext_bit,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  alu_sel_e        sel;
  logic            dec_illegal;
  logic [XLEN-1:0] sc_result;
  logic            sc_taken;
  logic            iter_start;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~kill;

  // decode
  always_comb begin
    sel         = ALU_ADD;
    dec_illegal = 1'b0;
    unique case (alu_op_e'(alu_op))
      ALU_OP_MEM: sel = ALU_ADD;
      ALU_OP_BRANCH: begin
        case (func3)
          3'b000:  sel = ALU_BEQ;
          3'b001:  sel = ALU_BNE;
          3'b100:  sel = ALU_BLT;
          3'b101:  sel = ALU_BGE;
          3'b110:  sel = ALU_BLTU;
          3'b111:  sel = ALU_BGEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      ALU_OP_REG: begin
        if (mext_bit) begin
`ifdef ALU_MEXT_EN
          sel         = alu_sel_e'({2'b10, func3});
          dec_illegal = sign_bit;
`else
          dec_illegal = 1'b1;
`endif
        end else begin
          case (func3)
            3'b000:  sel = sign_bit ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = sign_bit ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
          endcase
          if (sign_bit && func3 != 3'b000 && func3 != 3'b101) dec_illegal = 1'b1;
        end
      end
      ALU_OP_JUMP: begin
        sel = ALU_ADD;
        if (func3 != 3'b000) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // single-cycle datapath (also covers the one-cycle divide special cases)
  logic [SHW-1:0] shamt;
  assign shamt = opb[SHW-1:0];

`ifdef ALU_MEXT_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic div_zero, div_ovf, div_special;
  always_comb begin
    div_zero    = (opb == '0);
    div_ovf     = (sel == ALU_DIV || sel == ALU_REM) && opa == MOST_NEG && opb == '1;
    div_special = (sel == ALU_DIV || sel == ALU_DIVU || sel == ALU_REM || sel == ALU_REMU)
                  && (div_zero || div_ovf);
  end
  assign iter_start = is_mext_sel(sel) & ~dec_illegal & ~div_special;
`else
  assign iter_start = 1'b0;
`endif

  always_comb begin
    sc_result = '0;
    sc_taken  = 1'b0;
    case (sel)
      ALU_ADD:  sc_result = opa + opb;
      ALU_SUB:  sc_result = opa - opb;
      ALU_XOR:  sc_result = opa ^ opb;
      ALU_OR:   sc_result = opa | opb;
      ALU_AND:  sc_result = opa & opb;
      ALU_SLL:  sc_result = opa << shamt;
      ALU_SRL:  sc_result = opa >> shamt;
      ALU_SRA:  sc_result = $unsigned($signed(opa) >>> shamt);
      ALU_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      ALU_SLTU: sc_result = {{(XLEN-1){1'b0}}, (opa < opb)};
      ALU_BEQ:  sc_taken  = (opa == opb);
      ALU_BNE:  sc_taken  = (opa != opb);
      ALU_BLT:  sc_taken  = ($signed(opa) < $signed(opb));
      ALU_BGE:  sc_taken  = ($signed(opa) >= $signed(opb));
      ALU_BLTU: sc_taken  = (opa < opb);
      ALU_BGEU: sc_taken  = (opa >= opb);
`ifdef ALU_MEXT_EN
      // non-zero divisor here can only mean the most-negative / -1 case
      ALU_DIV, ALU_DIVU: sc_result = div_zero ? '1 : opa;
      ALU_REM, ALU_REMU: sc_result = div_zero ? opa : '0;
`endif
      default: ;
    endcase
    if (dec_illegal) begin
      sc_result = '0;
      sc_taken  = 1'b0;
    end
  end

`ifdef ALU_MEXT_EN
  logic            mdu_last;
  logic [XLEN-1:0] mdu_result;

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (kill),
    .start  (accept & iter_start),
    .step   (state_q == ST_BUSY),
    .func3  (func3),
    .opa    (opa),
    .opb    (opb),
    .last   (mdu_last),
    .result (mdu_result)
  );
`endif

  // next state and output registers; outputs are zero outside DONE
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_BUSY: begin
`ifdef ALU_MEXT_EN
        if (mdu_last) begin
          state_d   = ST_DONE;
          result_d  = mdu_result;
          taken_d   = 1'b0;
          illegal_d = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      state_d   = iter_start ? ST_BUSY : ST_DONE;
      result_d  = sc_result;
      taken_d   = sc_taken;
      illegal_d = dec_illegal;
    end
    if (kill) state_d = ST_IDLE;
    if (state_d != ST_DONE) begin
      result_d  = '0;
      taken_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid    = (state_q == ST_DONE);
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  func3 = 3'b000;
  logic        sign_bit = 1'b0;
  logic        mext_bit = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kill         (kill),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_op       (alu_op),
    .func3        (func3),
    .sign_bit     (sign_bit),
    .mext_bit     (mext_bit),
    .opa          (opa),
    .opb          (opb),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        sb;
    logic        mb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        tk;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [1:0] op, logic [2:0] f3, logic sb, logic mb,
                              logic [31:0] a, logic [31:0] b, logic [31:0] res,
                              logic tk, logic ill, int lat);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.sb = sb; v.mb = mb;
    v.a = a; v.b = b; v.res = res; v.tk = tk; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // M-extension vector: real result when built with the extension, else illegal
  function automatic vec_t mk_m(string nm, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                logic [31:0] res, int lat);
`ifdef ALU_MEXT_EN
    return mk(nm, 2'b10, f3, 1'b0, 1'b1, a, b, res, 1'b0, 1'b0, lat);
`else
    return mk(nm, 2'b10, f3, 1'b0, 1'b1, a, b, 32'h0, 1'b0, 1'b1, 1);
`endif
  endfunction

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic sb,
                       input logic mb, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; func3 = f3; sign_bit = sb; mext_bit = mb; opa = a; opb = b;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    @(negedge clk);
    drive(v.op, v.f3, v.sb, v.mb, v.a, v.b);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 1;
    seen = 0;
    while (!seen && lat <= 100) begin
      if (out_valid) seen = 1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({v.name, ".latency"}, 64'(lat), 64'(v.lat));
    check({v.name, ".result"}, {32'h0, result}, {32'h0, v.res});
    check({v.name, ".branch_taken"}, {63'h0, branch_taken}, {63'h0, v.tk});
    check({v.name, ".illegal"}, {63'h0, illegal}, {63'h0, v.ill});
    @(posedge clk);
    #1;
  endtask

  task automatic watch_quiet(input string nm, input int cycles);
    bit rose;
    rose = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) rose = 1;
    end
    check(nm, {63'h0, rose}, 64'h0);
  endtask

  initial begin
    vecs.push_back(mk("add",     2'b00, 3'b000, 0, 0, 32'd5,        32'd7,  32'd12,       0, 0, 1));
    vecs.push_back(mk("add_wrap",2'b00, 3'b000, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h0,        0, 0, 1));
    vecs.push_back(mk("blt",     2'b01, 3'b100, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h0,        1, 0, 1));
    vecs.push_back(mk("bltu",    2'b01, 3'b110, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h0,        0, 0, 1));
    vecs.push_back(mk("bge",     2'b01, 3'b101, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h0,        0, 0, 1));
    vecs.push_back(mk("bgeu",    2'b01, 3'b111, 0, 0, 32'hFFFFFFFF, 32'd1,  32'h0,        1, 0, 1));
    vecs.push_back(mk("beq",     2'b01, 3'b000, 0, 0, 32'd3,        32'd3,  32'h0,        1, 0, 1));
    vecs.push_back(mk("bne",     2'b01, 3'b001, 0, 0, 32'd3,        32'd3,  32'h0,        0, 0, 1));
    vecs.push_back(mk("sra",     2'b10, 3'b101, 1, 0, 32'h80000000, 32'd4,  32'hF8000000, 0, 0, 1));
    vecs.push_back(mk("srl",     2'b10, 3'b101, 0, 0, 32'h80000000, 32'd4,  32'h08000000, 0, 0, 1));
    vecs.push_back(mk("sub",     2'b10, 3'b000, 1, 0, 32'd5,        32'd7,  32'hFFFFFFFE, 0, 0, 1));
    vecs.push_back(mk("sll",     2'b10, 3'b001, 0, 0, 32'd1,        32'h24, 32'h10,       0, 0, 1));
    vecs.push_back(mk("slt",     2'b10, 3'b010, 0, 0, 32'hFFFFFFFF, 32'd1,  32'd1,        0, 0, 1));
    vecs.push_back(mk("sltu",    2'b10, 3'b011, 0, 0, 32'hFFFFFFFF, 32'd1,  32'd0,        0, 0, 1));
    vecs.push_back(mk("xor",     2'b10, 3'b100, 0, 0, 32'hF0F0,     32'hFF00, 32'h0FF0,   0, 0, 1));
    vecs.push_back(mk("or",      2'b10, 3'b110, 0, 0, 32'hF0F0,     32'hFF00, 32'hFFF0,   0, 0, 1));
    vecs.push_back(mk("and",     2'b10, 3'b111, 0, 0, 32'hF0F0,     32'hFF00, 32'hF000,   0, 0, 1));
    vecs.push_back(mk("jalr",    2'b11, 3'b000, 0, 0, 32'h1000,     32'h4,  32'h1004,     0, 0, 1));
    vecs.push_back(mk("ill_jmp", 2'b11, 3'b001, 0, 0, 32'h1000,     32'h4,  32'h0,        0, 1, 1));
    vecs.push_back(mk("ill_br",  2'b01, 3'b010, 0, 0, 32'd3,        32'd3,  32'h0,        0, 1, 1));
    vecs.push_back(mk("ill_sb",  2'b10, 3'b100, 1, 0, 32'd3,        32'd5,  32'h0,        0, 1, 1));
    vecs.push_back(mk("ill_msb", 2'b10, 3'b000, 1, 1, 32'd3,        32'd5,  32'h0,        0, 1, 1));
    vecs.push_back(mk_m("mulh",   3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33));
    vecs.push_back(mk_m("mulhu",  3'b011, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33));
    vecs.push_back(mk_m("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33));
    vecs.push_back(mk_m("mul",    3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33));
    vecs.push_back(mk_m("div0",   3'b100, 32'd7, 32'd0, 32'hFFFFFFFF, 1));
    vecs.push_back(mk_m("rem0",   3'b110, 32'd7, 32'd0, 32'd7, 1));
    vecs.push_back(mk_m("divu0",  3'b101, 32'd7, 32'd0, 32'hFFFFFFFF, 1));
    vecs.push_back(mk_m("remu0",  3'b111, 32'd7, 32'd0, 32'd7, 1));
    vecs.push_back(mk_m("div_ovf",3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
    vecs.push_back(mk_m("rem_ovf",3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk_m("divu_big",3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33));
    vecs.push_back(mk_m("remu_big",3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33));
    vecs.push_back(mk_m("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33));
    vecs.push_back(mk_m("remu",   3'b111, 32'd100, 32'd7, 32'd2, 33));
    vecs.push_back(mk_m("div_neg",3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33));
    vecs.push_back(mk_m("rem_neg",3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", {63'h0, out_valid}, 64'h0);
    check("rst.in_ready", {63'h0, in_ready}, 64'h1);
    check("rst.result", {32'h0, result}, 64'h0);
    check("rst.flags", {62'h0, branch_taken, illegal}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // stall: result held while out_ready low
    @(negedge clk);
    drive(2'b00, 3'b000, 0, 0, 32'h11, 32'h22);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    opa = 32'h5555;
    check("stall.in_ready", {63'h0, in_ready}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall.out_valid", {63'h0, out_valid}, 64'h1);
      check("stall.result", {32'h0, result}, 64'h33);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall.release", {31'h0, out_valid, result}, 64'h0);

    // back-to-back single-cycle ops
    @(negedge clk);
    drive(2'b00, 3'b000, 0, 0, 32'd1, 32'd2);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(2'b00, 3'b000, 0, 0, 32'd10, 32'd20);
    check("b2b.first", {31'h0, out_valid, result}, {31'h0, 1'b1, 32'd3});
    check("b2b.in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b.second", {31'h0, out_valid, result}, {31'h0, 1'b1, 32'd30});
    @(posedge clk);
    #1;
    check("b2b.idle", {63'h0, out_valid}, 64'h0);

    // kill while DONE and stalled
    @(negedge clk);
    drive(2'b00, 3'b000, 0, 0, 32'd4, 32'd4);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    out_ready = 1'b1;
    check("kill_done", {31'h0, out_valid, result}, 64'h0);

    // kill together with in_valid: no accept
    @(negedge clk);
    drive(2'b00, 3'b000, 0, 0, 32'd9, 32'd9);
    in_valid = 1'b1;
    kill     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill     = 1'b0;
    check("kill_accept.out_valid", {63'h0, out_valid}, 64'h0);
    watch_quiet("kill_accept.quiet", 3);

`ifdef ALU_MEXT_EN
    // kill at BUSY cycle 10
    @(negedge clk);
    drive(2'b10, 3'b000, 0, 1, 32'd3, 32'd5);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("kill_busy.in_ready", {63'h0, in_ready}, 64'h0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy.idle", {62'h0, out_valid, in_ready}, 64'h1);
    watch_quiet("kill_busy.quiet", 40);

    // asynchronous reset mid-BUSY
    @(negedge clk);
    drive(2'b10, 3'b001, 0, 1, 32'd3, 32'd5);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy.idle", {62'h0, out_valid, in_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet("rst_busy.quiet", 40);
`endif

    run_vec(mk("recover", 2'b00, 3'b000, 0, 0, 32'd100, 32'd23, 32'd123, 0, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
